// File: rtl/uart_frame_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_assembler
//  Description : Assembles HEADER/MIN/MAX/MED/CHK packets from the uart_rx
//                byte stream, validates the XOR checksum and presents the
//                24-bit {min, max, medido} word with a one-cycle load strobe.
//                An inter-byte watchdog aborts stalled frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_assembler #(
    parameter logic [7:0] HEADER  = 8'hAA,
    parameter int         TIMEOUT = 50000,
    localparam int        TW      = $clog2(TIMEOUT + 1)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    output logic [23:0] dados,
    output logic        pronto,
    output logic        erro_checksum,
    output logic        erro_timeout,
    output logic        ocupado,
    output logic [2:0]  db_estado
);

    // Frame-position states; the encoding is exported on db_estado.
    localparam logic [2:0] c_ESPERA = 3'd0;
    localparam logic [2:0] c_MINIMO = 3'd1;
    localparam logic [2:0] c_MAXIMO = 3'd2;
    localparam logic [2:0] c_MEDIDO = 3'd3;
    localparam logic [2:0] c_CHECK  = 3'd4;

    // Last count before the watchdog fires: it expires TIMEOUT edges after
    // the most recent byte.
    localparam logic [TW-1:0] c_TIMER_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_pesoMinimo;
    logic [7:0]    r_pesoMaximo;
    logic [7:0]    r_pesoMedido;
    logic [23:0]   r_dados;
    logic          r_pronto;
    logic          r_erroChecksum;
    logic          r_erroTimeout;

    logic          w_timeoutHit;
    logic [7:0]    w_checksum;

    // A byte arriving on the terminal count wins over the watchdog.
    assign w_timeoutHit = (r_state != c_ESPERA) && !rx_dv && (r_timer == c_TIMER_LAST);
    assign w_checksum   = r_pesoMinimo ^ r_pesoMaximo ^ r_pesoMedido;

    // Inter-byte watchdog: idle in ESPERA, restarted by every byte, saturating.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_timer <= '0;
        end else if (r_state == c_ESPERA || rx_dv) begin
            r_timer <= '0;
        end else if (r_timer != c_TIMER_LAST) begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // Frame parser FSM with registered result/error strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= c_ESPERA;
            r_pesoMinimo   <= 8'h00;
            r_pesoMaximo   <= 8'h00;
            r_pesoMedido   <= 8'h00;
            r_dados        <= 24'h0;
            r_pronto       <= 1'b0;
            r_erroChecksum <= 1'b0;
            r_erroTimeout  <= 1'b0;
        end else begin
            r_pronto       <= 1'b0;
            r_erroChecksum <= 1'b0;
            r_erroTimeout  <= 1'b0;
            if (w_timeoutHit) begin
                r_state       <= c_ESPERA;
                r_erroTimeout <= 1'b1;
            end else begin
                case (r_state)
                    c_ESPERA: begin
                        // Anything other than the header is line noise.
                        if (rx_dv && rx_byte == HEADER) begin
                            r_state <= c_MINIMO;
                        end
                    end
                    c_MINIMO: begin
                        if (rx_dv) begin
                            r_pesoMinimo <= rx_byte;
                            r_state      <= c_MAXIMO;
                        end
                    end
                    c_MAXIMO: begin
                        if (rx_dv) begin
                            r_pesoMaximo <= rx_byte;
                            r_state      <= c_MEDIDO;
                        end
                    end
                    c_MEDIDO: begin
                        if (rx_dv) begin
                            r_pesoMedido <= rx_byte;
                            r_state      <= c_CHECK;
                        end
                    end
                    c_CHECK: begin
                        if (rx_dv) begin
                            if (rx_byte == w_checksum) begin
                                r_dados  <= {r_pesoMinimo, r_pesoMaximo, r_pesoMedido};
                                r_pronto <= 1'b1;
                            end else begin
                                r_erroChecksum <= 1'b1;
                            end
                            r_state <= c_ESPERA;
                        end
                    end
                    default: begin
                        r_state <= c_ESPERA;
                    end
                endcase
            end
        end
    end

    assign dados         = r_dados;
    assign pronto        = r_pronto;
    assign erro_checksum = r_erroChecksum;
    assign erro_timeout  = r_erroTimeout;
    assign ocupado       = (r_state != c_ESPERA);
    assign db_estado     = r_state;

endmodule
`default_nettype wire
